// File: rtl/alu_pkg.sv
// alu_pkg: shared types for seq_alu.
//   op_e    - op_code encoding
//   err_e   - err_code encoding
//   state_e - control FSM states
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_MOD  = 4'h4,
        OP_AND  = 4'h5,
        OP_NAND = 4'h6,
        OP_NOR  = 4'h7,
        OP_NOTA = 4'h8,
        OP_OR   = 4'h9,
        OP_XNOR = 4'hA,
        OP_XOR  = 4'hB,
        OP_CLR  = 4'hC,
        OP_SET  = 4'hD,
        OP_HOLD = 4'hE,
        OP_EXP  = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_DIV0 = 2'b01,
        ERR_OVF  = 2'b10,
        ERR_ILL  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per step.
//   clk, rst  - clock, synchronous active-high reset
//   start     - load dividend/divisor and perform the first step in the same cycle
//   step      - perform one further step on the held state
//   dividend, divisor - operands (sampled only with start)
//   quotient, remainder - valid after WIDTH steps (start counts as one)
// The divisor must be non-zero; the caller filters divide-by-zero.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_in, quo_in, dvs_in;
    logic [WIDTH:0]   trial;
    logic             take;

    always_comb begin
        // On start the step works straight off the operands so the first
        // quotient bit is produced in the acceptance cycle.
        rem_in = start ? '0 : rem_q;
        quo_in = start ? dividend : quo_q;
        dvs_in = start ? divisor : dvs_q;
        // quo doubles as the dividend shift register: its MSB feeds the remainder.
        trial  = {rem_in, quo_in[WIDTH-1]};
        take   = (trial >= {1'b0, dvs_in});
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        if (start || step) begin
            rem_d = take ? WIDTH'(trial - {1'b0, dvs_in}) : trial[WIDTH-1:0];
            quo_d = {quo_in[WIDTH-2:0], take};
            dvs_d = dvs_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with accumulator, iterative divide/modulo and
// optional iterative exponent.
//   clk, rst           - clock, synchronous active-high reset
//   in_valid/in_ready  - request handshake (accept when both high)
//   op_code, in_a, in_b, acc_sel - request; acc_sel picks acc as operand B
//   out_valid          - one-cycle result strobe (no backpressure)
//   result, err_code   - held until the next out_valid
//   acc_out            - accumulator (loads result on error-free completion)
// Build option: define SEQ_ALU_EXP_EN to build the square-and-multiply
// exponent for op F; otherwise op F returns err_code 11.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             acc_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       err_code,
    output logic [WIDTH-1:0] acc_out
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    op_e                op_in, op_q, op_d;
    err_e               err_q, err_d, sc_err;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d, acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   op_b, sum, diff, sc_res, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic               accept, iterative, last, busy, div_start, div_step;

    assign op_in  = op_e'(op_code);
    assign op_b   = acc_sel ? acc_q : in_b;
    assign accept = in_valid && in_ready;
    assign busy   = (state_q == ST_BUSY);
    // cnt is 1 in the first BUSY cycle; WIDTH marks the completing cycle.
    assign last   = (cnt_q == CW'(WIDTH));
`ifdef SEQ_ALU_EXP_EN
    assign iterative = ((op_in == OP_DIV || op_in == OP_MOD) && op_b != '0) || op_in == OP_EXP;
`else
    assign iterative = (op_in == OP_DIV || op_in == OP_MOD) && op_b != '0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) state_d = iterative ? ST_BUSY : ST_DONE;
                else        state_d = ST_IDLE;
            end
            ST_BUSY: if (last) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q != ST_BUSY);
    end

    // ---------------- single-cycle ops ----------------
    assign sum  = in_a + op_b;
    assign diff = in_a - op_b;
    assign prod = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, op_b};

    always_comb begin
        sc_res = '0;
        sc_err = ERR_NONE;
        case (op_in)
            OP_ADD: begin
                sc_res = sum;
                if (in_a[WIDTH-1] == op_b[WIDTH-1] && sum[WIDTH-1] != in_a[WIDTH-1])
                    sc_err = ERR_OVF;
            end
            OP_SUB: begin
                sc_res = diff;
                if (in_a[WIDTH-1] != op_b[WIDTH-1] && diff[WIDTH-1] != in_a[WIDTH-1])
                    sc_err = ERR_OVF;
            end
            OP_MUL: begin
                sc_res = prod[WIDTH-1:0];
                if (prod[2*WIDTH-1:WIDTH] != '0) sc_err = ERR_OVF;
            end
            // Only reaches this path with a zero divisor.
            OP_DIV, OP_MOD: sc_err = ERR_DIV0;
            OP_AND:  sc_res = in_a & op_b;
            OP_NAND: sc_res = ~(in_a & op_b);
            OP_NOR:  sc_res = ~(in_a | op_b);
            OP_NOTA: sc_res = ~in_a;
            OP_OR:   sc_res = in_a | op_b;
            OP_XNOR: sc_res = ~(in_a ^ op_b);
            OP_XOR:  sc_res = in_a ^ op_b;
            OP_CLR:  sc_res = '0;
            OP_SET:  sc_res = '1;
            OP_HOLD: sc_res = acc_q;
            default: sc_err = ERR_ILL; // op F without the exponent unit
        endcase
    end

    // ---------------- divider ----------------
    assign div_start = accept && (op_in == OP_DIV || op_in == OP_MOD) && op_b != '0;
    assign div_step  = busy && !last;

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .step      (div_step),
        .dividend  (in_a),
        .divisor   (op_b),
        .quotient  (quo),
        .remainder (rem)
    );

`ifdef SEQ_ALU_EXP_EN
    // ---------------- exponent (left-to-right square-and-multiply) ----------------
    // Intermediates are exact powers of A with exponent <= B until the first
    // overflow, so a sticky flag on any overflowing product is exact.
    logic [WIDTH-1:0]   exp_res_q, exp_res_d, exp_e_q, exp_e_d, exp_base_q, exp_base_d;
    logic [WIDTH-1:0]   er_in, ee_in, eb_in;
    logic               exp_ov_q, exp_ov_d, eo_in, exp_start;
    logic [2*WIDTH-1:0] sq, mp;

    assign exp_start = accept && op_in == OP_EXP;

    always_comb begin
        er_in = exp_start ? WIDTH'(1) : exp_res_q;
        ee_in = exp_start ? op_b      : exp_e_q;
        eb_in = exp_start ? in_a      : exp_base_q;
        eo_in = exp_start ? 1'b0      : exp_ov_q;
        sq    = {{WIDTH{1'b0}}, er_in} * {{WIDTH{1'b0}}, er_in};
        mp    = {{WIDTH{1'b0}}, sq[WIDTH-1:0]} * {{WIDTH{1'b0}}, eb_in};
        exp_res_d  = exp_res_q;
        exp_e_d    = exp_e_q;
        exp_base_d = exp_base_q;
        exp_ov_d   = exp_ov_q;
        if (exp_start || div_step) begin
            exp_res_d  = ee_in[WIDTH-1] ? mp[WIDTH-1:0] : sq[WIDTH-1:0];
            exp_ov_d   = eo_in || (sq[2*WIDTH-1:WIDTH] != '0) ||
                         (ee_in[WIDTH-1] && mp[2*WIDTH-1:WIDTH] != '0);
            exp_e_d    = ee_in << 1;
            exp_base_d = eb_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_res_q  <= '0;
            exp_e_q    <= '0;
            exp_base_q <= '0;
            exp_ov_q   <= 1'b0;
        end else begin
            exp_res_q  <= exp_res_d;
            exp_e_q    <= exp_e_d;
            exp_base_q <= exp_base_d;
            exp_ov_q   <= exp_ov_d;
        end
    end
`endif

    // ---------------- result / accumulator ----------------
    always_comb begin
        result_d    = result_q;
        err_d       = err_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
        op_d        = op_q;
        if (busy) begin
            if (last) begin
                out_valid_d = 1'b1;
                err_d       = ERR_NONE;
                case (op_q)
                    OP_DIV:  result_d = quo;
                    OP_MOD:  result_d = rem;
`ifdef SEQ_ALU_EXP_EN
                    default: begin
                        result_d = exp_res_q;
                        if (exp_ov_q) err_d = ERR_OVF;
                    end
`else
                    default: result_d = '0;
`endif
                endcase
                if (err_d == ERR_NONE) acc_d = result_d;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (accept) begin
            op_d  = op_in;
            cnt_d = CW'(1);
            if (!iterative) begin
                out_valid_d = 1'b1;
                result_d    = sc_res;
                err_d       = sc_err;
                if (sc_err == ERR_NONE) acc_d = sc_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            err_q       <= ERR_NONE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            op_q        <= OP_ADD;
        end else begin
            result_q    <= result_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err_code  = err_q;
    assign acc_out   = acc_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=32). The driver pushes the
// expected {result, err, acc, arrival time} for each accepted request; the
// monitor pops and compares on every out_valid.
module tb_seq_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, acc_sel, out_valid;
    logic [3:0]   op_code;
    logic [W-1:0] in_a, in_b, result, acc_out;
    logic [1:0]   err_code;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .in_a      (in_a),
        .in_b      (in_b),
        .acc_sel   (acc_sel),
        .out_valid (out_valid),
        .result    (result),
        .err_code  (err_code),
        .acc_out   (acc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  err;
        logic [31:0] acc;
        time         t;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_acc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Low 32 bits of a^b plus whether the true value exceeds 32 bits.
    function automatic void pow_model(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic ovf);
        longint unsigned x;
        logic [31:0] base, k;
        ovf = 1'b0;
        if (a > 1 && b > 0) begin
            x = 1;
            for (longint unsigned i = 0; i < 64'(b) && !ovf; i++) begin
                x = x * 64'(a);
                if (x > 64'h0000_0000_FFFF_FFFF) ovf = 1'b1;
            end
        end
        r = 1; base = a; k = b;
        while (k != 0) begin
            if (k[0]) r = r * base;
            base = base * base;
            k = k >> 1;
        end
    endfunction

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] acc, output logic [31:0] r,
                                  output logic [1:0] e, output int lat);
        longint s;
        longint unsigned p;
        logic ovf;
        r = '0; e = 2'd0; lat = 1;
        case (op)
            4'h0: begin
                s = longint'($signed(a)) + longint'($signed(b)); r = a + b;
                if (s > 64'sd2147483647 || s < -64'sd2147483648) e = 2'd2;
            end
            4'h1: begin
                s = longint'($signed(a)) - longint'($signed(b)); r = a - b;
                if (s > 64'sd2147483647 || s < -64'sd2147483648) e = 2'd2;
            end
            4'h2: begin
                p = 64'(a) * 64'(b); r = a * b;
                if (p > 64'h0000_0000_FFFF_FFFF) e = 2'd2;
            end
            4'h3: if (b == 0) e = 2'd1; else begin r = a / b; lat = 33; end
            4'h4: if (b == 0) e = 2'd1; else begin r = a % b; lat = 33; end
            4'h5: r = a & b;
            4'h6: r = ~(a & b);
            4'h7: r = ~(a | b);
            4'h8: r = ~a;
            4'h9: r = a | b;
            4'hA: r = ~(a ^ b);
            4'hB: r = a ^ b;
            4'hC: r = '0;
            4'hD: r = 32'hFFFF_FFFF;
            4'hE: r = acc;
            default: begin
`ifdef SEQ_ALU_EXP_EN
                pow_model(a, b, r, ovf);
                e = ovf ? 2'd2 : 2'd0;
                lat = 33;
`else
                ovf = 1'b0;
                e = 2'd3 | {1'b0, ovf};
`endif
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic sel);
        exp_t e;
        int lat;
        int g = 0;
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            g++;
            if (g > 100) begin fail_now("ready_wait"); in_valid = 1'b0; return; end
        end
        in_valid = 1'b1; op_code = op; in_a = a; in_b = b; acc_sel = sel;
        @(posedge clk);
        model(op, a, sel ? m_acc : b, m_acc, e.res, e.err, lat);
        e.acc = (e.err == 2'd0) ? e.res : m_acc;
        m_acc = e.acc;
        e.t = $time + 10 * (lat - 1) + 5;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Idle cycles; while the DUT is busy, throw junk requests that must be ignored.
    task automatic gap(input int n);
        repeat (n) begin
            if (in_ready === 1'b0 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1; op_code = 4'($urandom); in_a = $urandom; in_b = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_out_valid");
            end else begin
                mon_e = sb.pop_front();
                chk("latency", 64'($time), 64'(mon_e.t));
                chk("result", 64'(result), 64'(mon_e.res));
                chk("err_code", 64'(err_code), 64'(mon_e.err));
                chk("acc_out", 64'(acc_out), 64'(mon_e.acc));
            end
        end
    end

    logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 20));
            1:       return $urandom;
            2:       return edges[$urandom_range(0, 4)];
            default: return 32'($urandom_range(0, 300));
        endcase
    endfunction

    initial begin
        int lowc, g;
        logic [3:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; in_valid = 1'b0; op_code = '0; in_a = '0; in_b = '0; acc_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_err", 64'(err_code), 64'd0);
        chk("rst_acc", 64'(acc_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(4'h0, 32'd5, 32'd7, 1'b0);            // 12
        issue(4'h2, 32'd3, 32'd0, 1'b1);            // 3*acc = 36
        issue(4'h0, 32'h7FFF_FFFF, 32'd1, 1'b0);    // overflow, acc kept
        issue(4'h3, 32'd100, 32'd7, 1'b0);          // 14 at +33
        lowc = 0; g = 0;
        while (out_valid !== 1'b1 && g < 100) begin
            if (in_ready === 1'b0) lowc++;
            @(negedge clk);
            g++;
        end
        chk("div_ready_low_cycles", 64'(lowc), 64'd32);
        chk("div_ready_at_done", 64'(in_ready), 64'd1);
        issue(4'h4, 32'd100, 32'd7, 1'b0);          // 2, accepted in DONE
        issue(4'h3, 32'd55, 32'd0, 1'b0);           // divide by zero
        issue(4'hF, 32'd3, 32'd4, 1'b0);            // 81 or illegal
        gap(40);

        // Reset abort mid-divide, with a request presented alongside reset.
        issue(4'h3, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; op_code = 4'h0; in_a = 32'd1; in_b = 32'd1; acc_sel = 1'b0;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        sb.delete();
        m_acc = '0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_acc", 64'(acc_out), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_err", 64'(err_code), 64'd0);
        gap(40);

        repeat (200) begin
            op = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            if (op == 4'hF && $urandom_range(0, 3) != 0) begin
                a = 32'($urandom_range(0, 6));
                b = 32'($urandom_range(0, 40));
            end
            issue(op, a, b, ($urandom_range(0, 3) == 0));
            gap($urandom_range(0, 3));
        end

        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand, result and accumulator width (8..64, even).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port list SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- op_code  in  4  operation select
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- acc_sel  in  1  1 = use accumulator as operand B instead of in_b
- out_valid  out  1  one-cycle result strobe
- result  out  WIDTH  operation result
- err_code  out  2  error status
- acc_out  out  WIDTH  accumulator contents

Function
REQ-004 A request SHALL be accepted on a rising clk edge where in_valid && in_ready; operands, op_code and acc_sel SHALL be captured at acceptance.
REQ-005 Op map: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 AND, 6 NAND, 7 NOR, 8 NOT A, 9 OR, A XNOR, B XOR, C clear (0), D preset (all ones), E hold (result = acc), F exponent A^B.
REQ-006 Single-cycle ops (0-2, 5-E) SHALL assert out_valid exactly 1 cycle after acceptance, with in_ready held high.
REQ-007 Div/mod SHALL run iteratively and assert out_valid exactly WIDTH+1 cycles after acceptance; in_ready SHALL be low from acceptance until the out_valid cycle.
REQ-008 FSM states SHALL be IDLE, BUSY and DONE: IDLE->DONE for single-cycle ops; IDLE->BUSY for div/mod/exp; BUSY->DONE when the iteration counter reaches its terminal value; DONE->IDLE unconditionally, and DONE SHALL accept a new request in the same cycle.
REQ-009 Arithmetic SHALL be two's-complement modulo 2^WIDTH, with the result being the low WIDTH bits.
REQ-010 err_code SHALL be 00 none, 01 divide-by-zero, 10 overflow, 11 illegal op; it SHALL be valid with out_valid and held until the next out_valid.
REQ-011 Overflow SHALL be flagged for signed add/sub overflow and for a multiply or exponent whose true product exceeds WIDTH bits unsigned.
REQ-012 Div/mod with divisor 0 SHALL return result 0 and err_code 01 with single-cycle latency, without entering BUSY.
REQ-013 On every out_valid with err_code 00, acc SHALL load result; on any error acc SHALL keep its value.
REQ-014 Op E SHALL leave acc unchanged.
REQ-015 in_valid while in_ready is low SHALL be ignored; out_valid SHALL have no backpressure.

Reset
REQ-016 rst SHALL force IDLE, in_ready=1, out_valid=0, result=0, err_code=00 and acc=0, aborting any BUSY operation; no out_valid SHALL be produced for an aborted request.
REQ-017 If rst and in_valid are both high, the request SHALL be dropped.

Configuration
REQ-018 With SEQ_ALU_EXP_EN defined, op F SHALL use square-and-multiply over the WIDTH bits of B, setting out_valid WIDTH+1 cycles after acceptance, with in_ready low meanwhile.
REQ-019 Without SEQ_ALU_EXP_EN, op F SHALL complete in 1 cycle with result 0 and err_code 11, and no exponent logic SHALL be synthesised.

Structure
REQ-020 Package alu_pkg SHALL hold the op_code enumeration, the err_code enumeration and the FSM state typedef.
REQ-021 The iterative divider SHALL be sub-module div_iter (restoring, one quotient bit per cycle, outputs quotient and remainder); the rest SHALL stay inline.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (WIDTH=32):
- Add: A=5, B=7, op 0 -> result 12, err 00, out_valid at +1, acc=12.
- Accumulate: op 2, A=3, acc_sel=1, acc=12 -> result 36.
- Add overflow: A=0x7FFFFFFF, B=1, op 0 -> err 10, acc unchanged.
- Divide: A=100, B=7, op 3 -> result 14 at +33, in_ready low 32 cycles; op 4 -> result 2.
- Divide by zero: op 3, B=0 -> result 0, err 01 at +1.
- Reset abort: rst asserted at cycle 10 of a divide -> no out_valid, acc=0, in_ready=1 next cycle.
- Exponent: A=3, B=4, op F -> 81 with SEQ_ALU_EXP_EN defined; err 11 without it.
